// File: rtl/fan_pkg.sv
// Shared fan definitions: speed levels seen by the PWM generator, keypad codes,
// scheduler state encodings and small level-stepping helpers.
package fan_pkg;

    // Faster levels have smaller codes, so "one level up" is a decrement.
    typedef enum logic [1:0] {
        SPD_HIGH   = 2'b00,
        SPD_MEDIUM = 2'b01,
        SPD_LOW    = 2'b10,
        SPD_OFF    = 2'b11
    } fan_speed_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RAMP   = 2'b01,
        ST_STEADY = 2'b10
    } fan_state_e;

    localparam logic [2:0] KEY_SPEED_UP   = 3'd1;
    localparam logic [2:0] KEY_SPEED_DOWN = 3'd2;
    localparam logic [2:0] KEY_POWER      = 3'd3;
    localparam logic [2:0] KEY_TIMER      = 3'd4;

    function automatic fan_speed_e level_up(input fan_speed_e s);
        return (s == SPD_HIGH) ? SPD_HIGH : fan_speed_e'(s - 2'd1);
    endfunction

    // Slowing down stops at LOW; OFF is reachable only through POWER or the timer.
    function automatic fan_speed_e level_down(input fan_speed_e s);
        return (s == SPD_LOW || s == SPD_OFF) ? s : fan_speed_e'(s + 2'd1);
    endfunction

    function automatic fan_speed_e step_toward(input fan_speed_e cur, input fan_speed_e tgt);
        fan_speed_e nxt;
        nxt = cur;
        if (tgt < cur) begin
            nxt = fan_speed_e'(cur - 2'd1);
        end else if (tgt > cur) begin
            nxt = fan_speed_e'(cur + 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fan_off_timer.sv
// Off-timer: cycles the 0/1/2/4-unit selection, counts down the armed interval
// and raises a one-cycle done pulse in the cycle the fan is switched off.
module fan_off_timer
    import fan_pkg::*;
#(
    parameter int unsigned TIMER_UNIT_CYC = 60000000
) (
    input  logic       clk_us,
    input  logic       rst,
    input  logic       advance,
    input  logic       clear,
    output logic [1:0] sel,
    output logic       expire,
    output logic       done
);

    localparam int CNT_W = $clog2(4 * TIMER_UNIT_CYC + 1);
    localparam logic [CNT_W-1:0] LOAD_1 = CNT_W'(TIMER_UNIT_CYC);
    localparam logic [CNT_W-1:0] LOAD_2 = CNT_W'(2 * TIMER_UNIT_CYC);
    localparam logic [CNT_W-1:0] LOAD_4 = CNT_W'(4 * TIMER_UNIT_CYC);

    logic [CNT_W-1:0] count_q;
    logic [1:0]       sel_q;
    logic [1:0]       sel_inc;
    logic [CNT_W-1:0] reload;

    assign sel_inc = sel_q + 2'd1;
    assign expire  = (count_q == CNT_W'(1));
    assign sel     = sel_q;

    always_comb begin
        reload = '0;
        case (sel_inc)
            2'd1:    reload = LOAD_1;
            2'd2:    reload = LOAD_2;
            2'd3:    reload = LOAD_4;
            default: reload = '0;
        endcase
    end

    // A count of 1 is the last armed cycle; the following edge performs the switch-off.
    always_ff @(posedge clk_us) begin
        if (rst) begin
            sel_q   <= 2'd0;
            count_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= expire;
            if (expire || clear) begin
                sel_q   <= 2'd0;
                count_q <= '0;
            end else if (advance) begin
                sel_q   <= sel_inc;
                count_q <= reload;
            end else if (count_q != '0) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fan_scheduler.sv
// Fan speed scheduler: keypad decoding, soft ramp between speed levels and
// power-off by key or by the off-timer.
module fan_scheduler
    import fan_pkg::*;
#(
    parameter int unsigned STEP_CYC       = 500000,
    parameter int unsigned TIMER_UNIT_CYC = 60000000
) (
    input  logic       clk_us,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [2:0] key_code,
    output logic [1:0] speed,
    output logic       ramping,
    output logic [1:0] timer_sel,
    output logic       timer_done,
    output fan_state_e state
);

    localparam int STEP_W = $clog2(STEP_CYC + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);

    fan_state_e        state_q, state_n;
    fan_speed_e        target_q, target_n;
    fan_speed_e        speed_q, speed_n;
    fan_speed_e        last_on_q, last_on_n;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_n;
    logic              ramping_q;
    logic              expire;
    logic              power_off;
    logic              timer_advance;

    fan_off_timer #(
        .TIMER_UNIT_CYC(TIMER_UNIT_CYC)
    ) u_off_timer (
        .clk_us (clk_us),
        .rst    (rst),
        .advance(timer_advance),
        .clear  (power_off),
        .sel    (timer_sel),
        .expire (expire),
        .done   (timer_done)
    );

    // key_valid is a one-cycle strobe with no ready: every strobe is taken on the edge
    // it is sampled, except when the off-timer expires on that same edge.
    always_comb begin
        state_n       = state_q;
        target_n      = target_q;
        speed_n       = speed_q;
        last_on_n     = last_on_q;
        step_cnt_n    = step_cnt_q;
        power_off     = 1'b0;
        timer_advance = 1'b0;

        if (expire) begin
            power_off = 1'b1;
        end else if (key_valid) begin
            case (key_code)
                KEY_SPEED_UP:   target_n = level_up(target_q);
                KEY_SPEED_DOWN: target_n = level_down(target_q);
                KEY_POWER: begin
                    if (target_q != SPD_OFF) begin
                        power_off = 1'b1;
                    end else begin
                        target_n = last_on_q;
                    end
                end
                KEY_TIMER:      timer_advance = (state_q != ST_IDLE);
                default:        ;
            endcase
        end

        if (power_off) begin
            target_n   = SPD_OFF;
            speed_n    = SPD_OFF;
            step_cnt_n = '0;
            state_n    = ST_IDLE;
        end else begin
            if (target_n != SPD_OFF) begin
                last_on_n = target_n;
            end
            // The step counter free-runs across target changes; only ramp entry restarts it.
            if (state_q == ST_RAMP) begin
                if (step_cnt_q == STEP_LAST) begin
                    speed_n    = step_toward(speed_q, target_n);
                    step_cnt_n = '0;
                end else begin
                    step_cnt_n = step_cnt_q + 1'b1;
                end
            end else begin
                step_cnt_n = '0;
            end
            if (speed_n == target_n) begin
                state_n = (target_n == SPD_OFF) ? ST_IDLE : ST_STEADY;
            end else begin
                state_n = ST_RAMP;
            end
        end
    end

    always_ff @(posedge clk_us) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            target_q   <= SPD_OFF;
            speed_q    <= SPD_OFF;
            last_on_q  <= SPD_MEDIUM;
            step_cnt_q <= '0;
            ramping_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            target_q   <= target_n;
            speed_q    <= speed_n;
            last_on_q  <= last_on_n;
            step_cnt_q <= step_cnt_n;
            ramping_q  <= (state_n == ST_RAMP);
        end
    end

    assign speed   = speed_q;
    assign ramping = ramping_q;
    assign state   = state_q;

endmodule

// File: tb/tb_fan_scheduler.sv
// Bench for fan_scheduler: directed scenarios plus random key traffic against a
// level/time-based reference model of the fan behaviour.
module tb_fan_scheduler;
    import fan_pkg::*;

    localparam int STEP = 10;
    localparam int UNIT = 100;

    logic       clk_us;
    logic       rst;
    logic       key_valid;
    logic [2:0] key_code;
    logic [1:0] speed;
    logic       ramping;
    logic [1:0] timer_sel;
    logic       timer_done;
    fan_state_e state;

    int checks = 0;
    int errors = 0;

    // Reference model: levels as ranks (OFF=0 .. HIGH=3), timing as absolute edge numbers.
    int cyc = 0;
    int m_tgt, m_spd, m_last, m_sel, m_next_step, m_deadline;
    bit m_ramp, m_done;

    fan_scheduler #(
        .STEP_CYC      (STEP),
        .TIMER_UNIT_CYC(UNIT)
    ) dut (
        .clk_us    (clk_us),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .speed     (speed),
        .ramping   (ramping),
        .timer_sel (timer_sel),
        .timer_done(timer_done),
        .state     (state)
    );

    initial clk_us = 1'b0;
    always #5 clk_us = ~clk_us;

    function automatic logic [1:0] enc(input int r);
        return 2'(3 - r);
    endfunction

    function automatic fan_state_e exp_state();
        if (m_tgt == 0) return ST_IDLE;
        return m_ramp ? ST_RAMP : ST_STEADY;
    endfunction

    function automatic void model_reset();
        m_tgt = 0; m_spd = 0; m_last = 2; m_sel = 0;
        m_next_step = 0; m_deadline = 0; m_ramp = 0; m_done = 0;
    endfunction

    function automatic void model_off();
        m_tgt = 0; m_spd = 0; m_ramp = 0; m_sel = 0; m_deadline = 0;
    endfunction

    function automatic void model_edge(input bit kv, input logic [2:0] kc);
        bit off;
        off = 0;
        m_done = 0;
        if (m_deadline != 0 && cyc == m_deadline) begin
            off = 1;
            m_done = 1;
        end else if (kv) begin
            case (kc)
                3'd1: if (m_tgt < 3) m_tgt = m_tgt + 1;
                3'd2: if (m_tgt > 1) m_tgt = m_tgt - 1;
                3'd3: if (m_tgt != 0) off = 1; else m_tgt = m_last;
                3'd4: if (m_tgt != 0) begin
                    m_sel = (m_sel + 1) % 4;
                    m_deadline = (m_sel == 0) ? 0 : cyc + ((m_sel == 3) ? 4 : m_sel) * UNIT;
                end
                default: ;
            endcase
        end
        if (off) begin
            model_off();
        end else begin
            if (m_tgt != 0) m_last = m_tgt;
            if (m_spd == m_tgt) begin
                m_ramp = 0;
            end else if (!m_ramp) begin
                m_ramp = 1;
                m_next_step = cyc + STEP;
            end else if (cyc == m_next_step) begin
                m_spd = (m_tgt > m_spd) ? m_spd + 1 : m_spd - 1;
                m_next_step = cyc + STEP;
                if (m_spd == m_tgt) m_ramp = 0;
            end
        end
    endfunction

    task automatic step(input logic kv, input logic [2:0] kc);
        key_valid = kv;
        key_code  = kc;
        @(posedge clk_us);
        cyc++;
        model_edge(kv, kc);
        #1;
        key_valid = 1'b0;
        key_code  = 3'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'd0);
    endtask

    task automatic do_reset(input bit with_key);
        rst       = 1'b1;
        key_valid = with_key;
        key_code  = KEY_POWER;
        @(posedge clk_us);
        cyc++;
        model_reset();
        #1;
        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = 3'd0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++;
        if (speed !== 2'b11 || ramping !== 1'b0 || timer_sel !== 2'd0 || timer_done !== 1'b0 || state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: speed=%b ramping=%b sel=%0d done=%b state=%0d want 11/0/0/0/IDLE",
                     speed, ramping, timer_sel, timer_done, state);
        end
    endtask

    task automatic test_power_ramp();
        do_reset(1'b0);
        step(1'b1, KEY_POWER);
        idle(9);
        checks++;
        if (speed !== 2'b11 || ramping !== 1'b1) begin
            errors++;
            $display("FAIL power_plus9: speed=%b ramping=%b want 11/1", speed, ramping);
        end
        idle(1);
        checks++;
        if (speed !== 2'b10 || ramping !== 1'b1) begin
            errors++;
            $display("FAIL power_plus10_low: speed=%b ramping=%b want 10/1", speed, ramping);
        end
        idle(9);
        checks++;
        if (speed !== 2'b10 || ramping !== 1'b1) begin
            errors++;
            $display("FAIL power_plus19: speed=%b ramping=%b want 10/1", speed, ramping);
        end
        idle(1);
        checks++;
        if (speed !== 2'b01 || ramping !== 1'b0 || state !== ST_STEADY) begin
            errors++;
            $display("FAIL power_plus20_medium: speed=%b ramping=%b state=%0d want 01/0/STEADY", speed, ramping, state);
        end
    endtask

    task automatic test_limits();
        do_reset(1'b0);
        step(1'b1, KEY_POWER);
        idle(20);
        step(1'b1, KEY_SPEED_UP);
        idle(10);
        checks++;
        if (speed !== 2'b00 || ramping !== 1'b0) begin
            errors++;
            $display("FAIL up_to_high: speed=%b ramping=%b want 00/0", speed, ramping);
        end
        step(1'b1, KEY_SPEED_UP);
        idle(12);
        checks++;
        if (speed !== 2'b00 || ramping !== 1'b0) begin
            errors++;
            $display("FAIL up_at_high: speed=%b ramping=%b want 00/0", speed, ramping);
        end
        step(1'b1, KEY_POWER);
        checks++;
        if (speed !== 2'b11 || ramping !== 1'b0 || state !== ST_IDLE) begin
            errors++;
            $display("FAIL power_off_direct: speed=%b ramping=%b state=%0d want 11/0/IDLE", speed, ramping, state);
        end
        step(1'b1, KEY_SPEED_UP);
        idle(10);
        step(1'b1, KEY_SPEED_DOWN);
        idle(12);
        checks++;
        if (speed !== 2'b10 || ramping !== 1'b0) begin
            errors++;
            $display("FAIL down_at_low: speed=%b ramping=%b want 10/0", speed, ramping);
        end
    endtask

    task automatic test_mid_ramp();
        do_reset(1'b0);
        step(1'b1, KEY_POWER);
        step(1'b1, KEY_SPEED_UP);
        idle(8);
        idle(1);
        checks++;
        if (speed !== 2'b10 || ramping !== 1'b1) begin
            errors++;
            $display("FAIL mid_low_at_10: speed=%b ramping=%b want 10/1", speed, ramping);
        end
        idle(4);
        step(1'b1, KEY_SPEED_DOWN);
        idle(4);
        checks++;
        if (speed !== 2'b10 || ramping !== 1'b1) begin
            errors++;
            $display("FAIL mid_before_20: speed=%b ramping=%b want 10/1", speed, ramping);
        end
        idle(1);
        checks++;
        if (speed !== 2'b01 || ramping !== 1'b0 || state !== ST_STEADY) begin
            errors++;
            $display("FAIL mid_medium_at_20: speed=%b ramping=%b state=%0d want 01/0/STEADY", speed, ramping, state);
        end
        idle(15);
        checks++;
        if (speed !== 2'b01 || ramping !== 1'b0) begin
            errors++;
            $display("FAIL mid_settled: speed=%b ramping=%b want 01/0", speed, ramping);
        end
    endtask

    task automatic test_timer();
        do_reset(1'b0);
        step(1'b1, KEY_POWER);
        idle(20);
        step(1'b1, KEY_TIMER);
        step(1'b1, KEY_TIMER);
        checks++;
        if (timer_sel !== 2'd2) begin
            errors++;
            $display("FAIL timer_sel_two: sel=%0d want 2", timer_sel);
        end
        idle(199);
        checks++;
        if (speed !== 2'b01 || timer_done !== 1'b0 || timer_sel !== 2'd2) begin
            errors++;
            $display("FAIL timer_before_expiry: speed=%b done=%b sel=%0d want 01/0/2", speed, timer_done, timer_sel);
        end
        idle(1);
        checks++;
        if (speed !== 2'b11 || timer_done !== 1'b1 || timer_sel !== 2'd0 || ramping !== 1'b0 || state !== ST_IDLE) begin
            errors++;
            $display("FAIL timer_expiry: speed=%b done=%b sel=%0d ramping=%b state=%0d want 11/1/0/0/IDLE",
                     speed, timer_done, timer_sel, ramping, state);
        end
        idle(1);
        checks++;
        if (timer_done !== 1'b0 || speed !== 2'b11) begin
            errors++;
            $display("FAIL timer_done_width: done=%b speed=%b want 0/11", timer_done, speed);
        end
        step(1'b1, KEY_POWER);
        idle(20);
        repeat (4) step(1'b1, KEY_TIMER);
        checks++;
        if (timer_sel !== 2'd0) begin
            errors++;
            $display("FAIL timer_wrap: sel=%0d want 0", timer_sel);
        end
        idle(450);
        checks++;
        if (speed !== 2'b01 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL timer_disarmed: speed=%b done=%b want 01/0", speed, timer_done);
        end
    endtask

    task automatic test_expiry_key();
        do_reset(1'b0);
        step(1'b1, KEY_POWER);
        idle(20);
        step(1'b1, KEY_TIMER);
        idle(99);
        step(1'b1, KEY_SPEED_UP);
        checks++;
        if (speed !== 2'b11 || timer_done !== 1'b1 || state !== ST_IDLE) begin
            errors++;
            $display("FAIL expiry_beats_key: speed=%b done=%b state=%0d want 11/1/IDLE", speed, timer_done, state);
        end
        idle(5);
        checks++;
        if (speed !== 2'b11 || state !== ST_IDLE) begin
            errors++;
            $display("FAIL expiry_stays_off: speed=%b state=%0d want 11/IDLE", speed, state);
        end
        step(1'b1, KEY_POWER);
        idle(30);
        checks++;
        if (speed !== 2'b01 || ramping !== 1'b0) begin
            errors++;
            $display("FAIL expiry_restore_last_on: speed=%b ramping=%b want 01/0", speed, ramping);
        end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset(1'b0);
        step(1'b1, KEY_POWER);
        step(1'b1, KEY_SPEED_UP);
        idle(13);
        do_reset(1'b1);
        checks++;
        if (speed !== 2'b11 || ramping !== 1'b0 || state !== ST_IDLE || timer_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_ramp: speed=%b ramping=%b state=%0d sel=%0d want 11/0/IDLE/0",
                     speed, ramping, state, timer_sel);
        end
        step(1'b1, KEY_POWER);
        idle(20);
        checks++;
        if (speed !== 2'b01 || ramping !== 1'b0) begin
            errors++;
            $display("FAIL reset_last_on_medium: speed=%b ramping=%b want 01/0", speed, ramping);
        end
    endtask

    task automatic test_random();
        do_reset(1'b0);
        for (int i = 0; i < 4000; i++) begin
            logic       kv;
            logic [2:0] kc;
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                kv = ($urandom_range(0, 24) == 0);
                kc = 3'($urandom_range(0, 7));
                step(kv, kc);
            end
            checks++;
            if (speed !== enc(m_spd) || ramping !== m_ramp || timer_sel !== 2'(m_sel) ||
                timer_done !== m_done || state !== exp_state()) begin
                errors++;
                $display("FAIL random_cycle %0d: speed=%b ramp=%b sel=%0d done=%b state=%0d want %b/%b/%0d/%b/%0d",
                         i, speed, ramping, timer_sel, timer_done, state,
                         enc(m_spd), m_ramp, m_sel, m_done, exp_state());
            end
            if (errors > 50) break;
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 3'd0;
        model_reset();
        test_reset();
        test_power_ramp();
        test_limits();
        test_mid_ramp();
        test_timer();
        test_expiry_key();
        test_reset_mid_ramp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fan_scheduler.md
FAN_SCHEDULER -- requirements
Module: fan_scheduler

Interface
REQ-001 Parameter STEP_CYC, default 500000, clk_us cycles between single-level speed steps during a ramp.
REQ-002 Parameter TIMER_UNIT_CYC, default 60000000, clk_us cycles per off-timer unit.
REQ-003 clk_us  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key_valid  input  1  one-cycle pulse; key_code valid this cycle; every pulse is accepted, with no back-pressure.
REQ-006 key_code  input  3  1=SPEED_UP, 2=SPEED_DOWN, 3=POWER, 4=TIMER; all other codes are ignored.
REQ-007 speed  output  2  level to PWM generator: HIGH=00, MEDIUM=01, LOW=10, OFF=11.
REQ-008 ramping  output  1  high while speed differs from target.
REQ-009 timer_sel  output  2  off-timer setting: 0=none, 1=1 unit, 2=2 units, 3=4 units.
REQ-010 timer_done  output  1  one-cycle pulse when the off-timer expires.

Function
REQ-011 Level order OFF<LOW<MEDIUM<HIGH; registers: target, speed, last_on (last non-OFF target), step counter, timer counter.
REQ-012 FSM states: IDLE (target=OFF, speed=OFF), RAMP (speed!=target), STEADY (speed=target!=OFF).
REQ-013 SPEED_UP: target OFF->LOW, LOW->MEDIUM, MEDIUM->HIGH; at HIGH, no change.
REQ-014 SPEED_DOWN: HIGH->MEDIUM, MEDIUM->LOW; at LOW or OFF, no change (never reaches OFF).
REQ-015 POWER with target!=OFF: target, speed <= OFF next cycle (no ramp); timer_sel <= 0; state -> IDLE.
REQ-016 POWER with target=OFF: target <= last_on (reset value MEDIUM).
REQ-017 Any key making speed!=target: state -> RAMP next cycle; step counter cleared only on entry from IDLE/STEADY.
REQ-018 In RAMP, speed moves one level toward target every STEP_CYC cycles; first step STEP_CYC cycles after the acceptance edge.
REQ-019 Leaving OFF always passes through LOW (soft start): OFF->HIGH takes 3*STEP_CYC cycles.
REQ-020 Target change mid-ramp: the step counter is not restarted; ramp continues toward the new target; if speed equals the new target, go to STEADY next cycle.
REQ-021 TIMER in IDLE: ignored; otherwise timer_sel increments 0->1->2->3->0, and the countdown reloads to sel units (1, 2 or 4) x TIMER_UNIT_CYC; sel 0 disarms.
REQ-022 Timer counter width covers 4*TIMER_UNIT_CYC without overflow; the step counter covers STEP_CYC.
REQ-023 Countdown reaching 1: next cycle has the POWER-off effect (REQ-015), and timer_done pulses for exactly one cycle.
REQ-024 Timer expiry and key_valid in the same cycle: expiry wins; the key is dropped.
REQ-025 last_on updates whenever target is set to a non-OFF value.
REQ-026 ramping = (state==RAMP), registered; speed changes only on clock edges (glitch-free).

Reset
REQ-027 rst high at the clock edge: speed=OFF, target=OFF, last_on=MEDIUM, ramping=0, timer_sel=0, timer_done=0, counters=0, state=IDLE.
REQ-028 Reset mid-ramp or mid-countdown aborts immediately; key_valid during reset is ignored.

Structure
REQ-029 Speed encodings (HIGH/MEDIUM/LOW/OFF), key codes and FSM state encodings belong in the shared fan package, also used by the PWM generator.
REQ-030 One sub-module, fan_off_timer (countdown, reload, timer_done), is instantiated; the ramp FSM stays in fan_scheduler.

Verification (STEP_CYC=10, TIMER_UNIT_CYC=100)
REQ-031 Reset, then POWER -> speed OFF->LOW at +10 and LOW->MEDIUM at +20; ramping falls with the MEDIUM step.
REQ-032 From STEADY HIGH, SPEED_UP -> no change, ramping stays 0; from LOW, SPEED_DOWN -> stays LOW.
REQ-033 Ramp toward HIGH, SPEED_DOWN at +5 after reaching LOW -> reaches MEDIUM at the original +10 boundary, then STEADY.
REQ-034 STEADY MEDIUM, TIMER twice (sel=2) -> 200 cycles later speed=OFF, timer_done one-cycle pulse, timer_sel=0.
REQ-035 Timer expiry coincident with a SPEED_UP key -> OFF wins; target OFF; the next POWER restores last_on.
REQ-036 rst asserted mid-ramp at HIGH target -> next cycle speed=OFF, ramping=0, last_on=MEDIUM.
